// File: rtl/adc_buf_pkg.sv
// Shared defaults and types for the ADC frame buffer.
package adc_buf_pkg;
  localparam int INPUT_BIT   = 3;
  localparam int PARALLEL    = 10;
  localparam int PERIOD      = 32;
  localparam int FRAME_CNT_W = 16;

  typedef logic [INPUT_BIT-1:0] symbol_t;
  typedef symbol_t [PARALLEL-1:0] beat_t;
endpackage

// File: rtl/adc_frame_bank.sv
// One frame bank: DEPTH beats of BEAT_W bits, written one beat at a time.
module adc_frame_bank #(
  parameter int BEAT_W = 30,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      i_we,
  input  logic [IDX_W-1:0]          i_idx,
  input  logic [BEAT_W-1:0]         i_data,
  output logic [DEPTH*BEAT_W-1:0]   o_frame
);

  logic [DEPTH*BEAT_W-1:0] r_mem;

  // Store the incoming beat at its slot; contents survive until overwritten.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mem <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i_we && (i_idx == IDX_W'(i))) begin
          r_mem[i*BEAT_W +: BEAT_W] <= i_data;
        end
      end
    end
  end

  assign o_frame = r_mem;

endmodule

// File: rtl/adc_frame_buffer.sv
// Ping-pong ADC frame collector: one bank fills while the other is presented.
module adc_frame_buffer
  import adc_buf_pkg::*;
#(
  parameter int INPUT_BIT = adc_buf_pkg::INPUT_BIT,
  parameter int PARALLEL  = adc_buf_pkg::PARALLEL,
  parameter int PERIOD    = adc_buf_pkg::PERIOD
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                CE,
  input  logic                                FLUSH,
  input  logic                                IN_VALID,
  output logic                                IN_READY,
  input  logic [PARALLEL*INPUT_BIT-1:0]       INPUT,
  output logic                                OUT_VALID,
  input  logic                                OUT_READY,
  output logic [PERIOD*PARALLEL*INPUT_BIT-1:0] SYMBOL_BUFFER,
  output logic                                OVERRUN,
  output logic [FRAME_CNT_W-1:0]              FRAME_CNT
);

  localparam int CNT_BIT = $clog2(PERIOD);
  localparam int BEAT_W  = PARALLEL * INPUT_BIT;
  localparam int FRAME_W = PERIOD * BEAT_W;

  logic [CNT_BIT-1:0]     r_cnt;
  logic                   r_wr_bank;
  logic                   r_rd_bank;
  logic [1:0]             r_full;
  logic                   r_overrun;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_release;
  logic [FRAME_W-1:0]     w_frame0;
  logic [FRAME_W-1:0]     w_frame1;

  // Ready drops combinationally during reset, on flush, or when the fill bank is occupied.
  assign w_in_ready = RST_N & ~r_full[r_wr_bank] & ~FLUSH;
  assign w_accept   = CE & IN_VALID & w_in_ready;
  assign w_last     = (r_cnt == CNT_BIT'(PERIOD - 1));
  assign w_release  = r_full[r_rd_bank] & OUT_READY;

  adc_frame_bank #(.BEAT_W(BEAT_W), .DEPTH(PERIOD), .IDX_W(CNT_BIT)) u_bank0 (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_we    (w_accept & ~r_wr_bank),
    .i_idx   (r_cnt),
    .i_data  (INPUT),
    .o_frame (w_frame0)
  );

  adc_frame_bank #(.BEAT_W(BEAT_W), .DEPTH(PERIOD), .IDX_W(CNT_BIT)) u_bank1 (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_we    (w_accept & r_wr_bank),
    .i_idx   (r_cnt),
    .i_data  (INPUT),
    .o_frame (w_frame1)
  );

  // Beat counter, bank pointers, full flags, overrun and delivered-frame count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt       <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_full      <= '0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
    end else if (FLUSH) begin
      r_cnt     <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_full    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_cnt             <= '0;
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // A bank being released can never be the one completing: its full flag blocks writes.
      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
        r_frame_cnt       <= r_frame_cnt + 1'b1;
      end
      if (CE && IN_VALID && !w_in_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign IN_READY      = w_in_ready;
  assign OUT_VALID     = r_full[r_rd_bank];
  assign SYMBOL_BUFFER = r_rd_bank ? w_frame1 : w_frame0;
  assign OVERRUN       = r_overrun;
  assign FRAME_CNT     = r_frame_cnt;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Bench: two builds (PERIOD=4 and PERIOD=5) driven in lockstep against a frame-queue model.
module tb_adc_frame_buffer;
  localparam int IB = 3;
  localparam int PL = 2;
  localparam int BW = IB * PL;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST_N, CE, FLUSH, IN_VALID, OUT_READY;
  logic [BW-1:0] INPUT;

  logic [1:0]    w_rdy, w_vld, w_ovr;
  logic [15:0]   w_fc0, w_fc1;
  logic [23:0]   w_sb0;
  logic [29:0]   w_sb1;

  adc_frame_buffer #(.INPUT_BIT(IB), .PARALLEL(PL), .PERIOD(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .FLUSH(FLUSH), .IN_VALID(IN_VALID),
    .IN_READY(w_rdy[0]), .INPUT(INPUT), .OUT_VALID(w_vld[0]), .OUT_READY(OUT_READY),
    .SYMBOL_BUFFER(w_sb0), .OVERRUN(w_ovr[0]), .FRAME_CNT(w_fc0)
  );

  adc_frame_buffer #(.INPUT_BIT(IB), .PARALLEL(PL), .PERIOD(5)) u_dut5 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .FLUSH(FLUSH), .IN_VALID(IN_VALID),
    .IN_READY(w_rdy[1]), .INPUT(INPUT), .OUT_VALID(w_vld[1]), .OUT_READY(OUT_READY),
    .SYMBOL_BUFFER(w_sb1), .OVERRUN(w_ovr[1]), .FRAME_CNT(w_fc1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Model: per build, a partially assembled frame plus a FIFO of up to two complete frames.
  int          m_per  [2] = '{4, 5};
  int          m_cnt  [2];
  logic [63:0] m_part [2];
  logic [63:0] m_fq   [2][2];
  int          m_fn   [2];
  bit          m_ovr  [2];
  int          m_fc   [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_part[d] = '0; m_fn[d] = 0; m_ovr[d] = 0; m_fc[d] = 0;
      m_fq[d][0] = '0; m_fq[d][1] = '0;
    end
  endtask

  task automatic check_all(input string ph);
    for (int d = 0; d < 2; d++) begin
      bit exp_rdy, exp_vld;
      exp_rdy = RST_N && (m_fn[d] < 2) && !FLUSH;
      exp_vld = (m_fn[d] > 0);
      chk($sformatf("%s_d%0d_in_ready", ph, d), 64'(d == 0 ? w_rdy[0] : w_rdy[1]), 64'(exp_rdy));
      chk($sformatf("%s_d%0d_out_valid", ph, d), 64'(d == 0 ? w_vld[0] : w_vld[1]), 64'(exp_vld));
      chk($sformatf("%s_d%0d_overrun", ph, d), 64'(d == 0 ? w_ovr[0] : w_ovr[1]), 64'(m_ovr[d]));
      chk($sformatf("%s_d%0d_frame_cnt", ph, d), 64'(d == 0 ? w_fc0 : w_fc1), 64'(m_fc[d]));
      if (exp_vld)
        chk($sformatf("%s_d%0d_buffer", ph, d), (d == 0 ? 64'(w_sb0) : 64'(w_sb1)), m_fq[d][0]);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit rdy, vld;
      rdy = (m_fn[d] < 2) && !FLUSH;
      vld = (m_fn[d] > 0);
      if (FLUSH) begin
        m_cnt[d] = 0; m_part[d] = '0; m_fn[d] = 0; m_ovr[d] = 0;
      end else begin
        if (vld && OUT_READY) begin
          m_fq[d][0] = m_fq[d][1];
          m_fn[d]--;
          m_fc[d] = (m_fc[d] + 1) % 65536;
        end
        if (CE && IN_VALID && !rdy) m_ovr[d] = 1;
        if (CE && IN_VALID && rdy) begin
          m_part[d] = m_part[d] | (64'(INPUT) << (m_cnt[d] * BW));
          m_cnt[d]++;
          if (m_cnt[d] == m_per[d]) begin
            m_fq[d][m_fn[d]] = m_part[d];
            m_fn[d]++;
            m_part[d] = '0;
            m_cnt[d] = 0;
          end
        end
      end
    end
  endtask

  // Inputs are already set; check outputs mid-cycle, then advance model and clock.
  task automatic cycle(input string ph);
    @(negedge CLK);
    check_all(ph);
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit ce, input bit fl, input bit iv, input bit ordy, input logic [BW-1:0] data);
    CE = ce; FLUSH = fl; IN_VALID = iv; OUT_READY = ordy; INPUT = data;
  endtask

  int base_fc;

  initial begin
    RST_N = 1'b0;
    drive(0, 0, 0, 0, '0);
    model_reset();
    repeat (2) cycle("rst");
    chk("rst_buffer4", 64'(w_sb0), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Reset in the middle of a frame: valid and ready fall without a clock edge.
    drive(1, 0, 1, 0, 6'o12); cycle("mid");
    drive(1, 0, 1, 0, 6'o34); cycle("mid");
    drive(1, 0, 1, 0, 6'o56); cycle("mid");
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_valid4", 64'(w_vld[0]), 64'd0);
    chk("async_rst_ready4", 64'(w_rdy[0]), 64'd0);
    chk("async_rst_buf4", 64'(w_sb0), 64'd0);
    model_reset();
    drive(0, 0, 0, 0, '0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    cycle("post_rst");

    // Single frame with a stalled consumer.
    drive(1, 0, 1, 0, 6'o11); cycle("t2");
    drive(1, 0, 1, 0, 6'o22); cycle("t2");
    drive(1, 0, 1, 0, 6'o33); cycle("t2");
    drive(1, 0, 1, 0, 6'o44); cycle("t2");
    drive(0, 0, 0, 0, '0);
    chk("t2_valid", 64'(w_vld[0]), 64'd1);
    chk("t2_buffer", 64'(w_sb0), 64'o44332211);
    cycle("t2");
    drive(0, 0, 0, 1, '0); cycle("t2");
    drive(0, 0, 0, 0, '0);
    chk("t2_frame_cnt", 64'(w_fc0), 64'd1);
    cycle("t2");

    // Back-pressure: nine beats into two banks, then drain.
    drive(0, 1, 0, 0, '0); cycle("t3_flush");
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 1, 0, BW'($urandom)); cycle("t3_fill");
    end
    drive(0, 0, 0, 0, '0);
    chk("t3_overrun4", 64'(w_ovr[0]), 64'd1);
    chk("t3_ready4", 64'(w_rdy[0]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, '0); cycle("t3_drain");
    end

    // Streaming with the consumer always ready.
    drive(0, 1, 0, 0, '0); cycle("t4_flush");
    base_fc = m_fc[0];
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 1, BW'($urandom)); cycle("t4_stream");
    end
    drive(0, 0, 0, 1, '0); cycle("t4_tail");
    chk("t4_frames4", 64'(w_fc0), 64'((base_fc + 5) % 65536));
    chk("t4_overrun4", 64'(w_ovr[0]), 64'd0);

    // CE gaps, then a flush after two beats.
    for (int i = 0; i < 8; i++) begin
      drive(i % 2, 0, 1, 1, BW'($urandom)); cycle("t5_ce");
    end
    drive(1, 0, 1, 1, BW'($urandom)); cycle("t5_pre");
    drive(1, 0, 1, 1, BW'($urandom)); cycle("t5_pre");
    drive(1, 1, 1, 0, BW'($urandom)); cycle("t5_flush");
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 0, BW'($urandom)); cycle("t5_fresh");
    end
    drive(0, 0, 0, 1, '0);
    repeat (3) cycle("t5_drain");

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      bit fl;
      fl = ($urandom_range(0, 31) == 0);
      drive($urandom_range(0, 3) != 0, fl, $urandom_range(0, 3) != 0,
            fl ? 1'b0 : 1'($urandom_range(0, 1)), BW'($urandom));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
